// File: rtl/mem_lsu.sv
`default_nettype none
// mem_lsu: MEM-stage load/store unit with a posted store buffer and a req/gnt/rvalid data bus.
// Revision 1.0
module mem_lsu #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_memread,
  input  logic            i_memwrite,
  input  logic            i_fence,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_rd,
  output logic            o_stall,
  output logic            o_ex_ld_addr,
  output logic            o_ex_st_addr,
  output logic            o_sb_empty,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    LD_DONE = 3'd3,
    ST_REQ  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [XLEN-3:0]     sb_addr [SB_DEPTH];
  logic [XLEN-1:0]     sb_data [SB_DEPTH];
  logic [3:0]          sb_be   [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;

  logic            is_byte, is_half, misal, ld_req, st_req, full, push, pop;
  logic            hit, alias_hold, alias_hold_nx, ld_go, ld_cap;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_data;
  logic [1:0]      ld_lane;
  logic [2:0]      ld_f3;
  logic            req_nx, we_nx;
  logic [XLEN-1:0] addr_nx, wdata_nx;
  logic [3:0]      be_nx;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                              input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic [XLEN-1:0] s;
    s = w >> {lane, 3'b000};
    case (f3)
      3'b000:  extract = {{(XLEN-8){s[7]}}, s[7:0]};
      3'b001:  extract = {{(XLEN-16){s[15]}}, s[15:0]};
      3'b100:  extract = {{(XLEN-8){1'b0}}, s[7:0]};
      3'b101:  extract = {{(XLEN-16){1'b0}}, s[15:0]};
      default: extract = w;
    endcase
  endfunction

  assign is_byte      = (i_f3[1:0] == 2'b00);
  assign is_half      = (i_f3[1:0] == 2'b01);
  assign misal        = (is_half & i_addr[0]) | (~is_byte & ~is_half & (i_addr[1:0] != 2'b00));
  assign ld_req       = i_valid & i_memread & ~misal;
  assign st_req       = i_valid & i_memwrite & ~misal;
  assign o_ex_ld_addr = i_valid & i_memread & misal;
  assign o_ex_st_addr = i_valid & i_memwrite & misal;
  assign full         = (count == FULL_CNT);
  assign o_sb_empty   = (count == '0);
  assign push         = st_req & ~full;
  assign st_data      = i_wr_data << {i_addr[1:0], 3'b000};

  always_comb begin
    st_be = 4'b1111;
    if (is_byte)      st_be = 4'b0001 << i_addr[1:0];
    else if (is_half) st_be = 4'b0011 << {i_addr[1], 1'b0};
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (sb_vld[i] && (sb_addr[i] == i_addr[XLEN-1:2])) hit = 1'b1;
  end

  // Once a load has aliased, it keeps waiting for a fully empty buffer even
  // after its own word has drained.
  assign alias_hold_nx = ld_req & ~o_sb_empty & (hit | alias_hold);
  assign ld_go = ld_req & (state == IDLE) & (o_sb_empty | (~hit & ~alias_hold));

  assign o_stall = (st_req & full) | (i_valid & i_fence & ~o_sb_empty) |
                   (ld_req & (state != LD_DONE));

  always_comb begin
    state_nx = state;
    req_nx   = o_mem_req;
    we_nx    = o_mem_we;
    addr_nx  = o_mem_addr;
    wdata_nx = o_mem_wdata;
    be_nx    = o_mem_be;
    pop      = 1'b0;
    ld_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_go) begin
          state_nx = LD_REQ;
          req_nx   = 1'b1;
          we_nx    = 1'b0;
          addr_nx  = {i_addr[XLEN-1:2], 2'b00};
          be_nx    = 4'b1111;
        end else if (!o_sb_empty) begin
          state_nx = ST_REQ;
          req_nx   = 1'b1;
          we_nx    = 1'b1;
          addr_nx  = {sb_addr[rd_ptr], 2'b00};
          wdata_nx = sb_data[rd_ptr];
          be_nx    = sb_be[rd_ptr];
        end
      end
      LD_REQ: begin
        if (i_mem_gnt) begin
          state_nx = LD_WAIT;
          req_nx   = 1'b0;
        end
      end
      LD_WAIT: begin
        if (i_mem_rvalid) begin
          state_nx = LD_DONE;
          ld_cap   = 1'b1;
        end
      end
      LD_DONE: state_nx = IDLE;
      ST_REQ: begin
        if (i_mem_gnt) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          pop      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sb_vld      <= '0;
      alias_hold  <= 1'b0;
      ld_lane     <= 2'b00;
      ld_f3       <= 3'b000;
      o_rd        <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= 4'b0000;
    end else begin
      state       <= state_nx;
      count       <= count + CW'(push) - CW'(pop);
      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr + PW'(pop);
      alias_hold  <= alias_hold_nx;
      o_mem_req   <= req_nx;
      o_mem_we    <= we_nx;
      o_mem_addr  <= addr_nx;
      o_mem_wdata <= wdata_nx;
      o_mem_be    <= be_nx;
      if (pop)  sb_vld[rd_ptr] <= 1'b0;
      if (push) sb_vld[wr_ptr] <= 1'b1;
      if (ld_go) begin
        ld_lane <= i_addr[1:0];
        ld_f3   <= i_f3;
      end
      if (ld_cap) o_rd <= extract(i_mem_rdata, ld_lane, ld_f3);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      sb_addr[wr_ptr] <= i_addr[XLEN-1:2];
      sb_data[wr_ptr] <= st_data;
      sb_be[wr_ptr]   <= st_be;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// tb_mem_lsu: scoreboard bench for mem_lsu with a randomized bus responder and a word-level memory model.
// Revision 1.0
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, memread, memwrite, fence;
  logic [2:0]  f3;
  logic [31:0] addr, wr_data;
  logic [31:0] rd;
  logic        stall, ex_ld, ex_st, sb_empty, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  int errors = 0, checks = 0, pops = 0;
  int gnt_mode = 0, rv_min = 0, rv_max = 0;
  bit rv_pend = 1'b0;
  int rv_cnt = 0;
  logic [31:0] rv_data = '0;

  bit [31:0]   arch_mem [int unsigned];
  bit [31:0]   bus_mem  [int unsigned];
  st_t         st_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] la_q[$];
  bit          hs_log[$];

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32), .SB_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_memread(memread),
    .i_memwrite(memwrite), .i_fence(fence), .i_f3(f3), .i_addr(addr),
    .i_wr_data(wr_data), .o_rd(rd), .o_stall(stall), .o_ex_ld_addr(ex_ld),
    .o_ex_st_addr(ex_st), .o_sb_empty(sb_empty), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_be(mem_be), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] seed(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic bit [31:0] arch_rd(input int unsigned wa);
    return arch_mem.exists(wa) ? arch_mem[wa] : seed(wa);
  endfunction

  function automatic bit [31:0] bus_rd(input int unsigned wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : seed(wa);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] fc);
    logic [31:0] s;
    s = w >> (8 * lane);
    case (fc)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Monitor and bus responder.
  initial begin
    bit hs;
    st_t e;
    bit [31:0] w;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && mem_req && mem_gnt;
      if (rst_n && valid && memread && !ex_ld && !stall) begin
        if (rd_q.size() == 0) chk("unexpected_load_done", 32'(1), 32'(0));
        else chk("load_rd", rd, rd_q.pop_front());
      end
      if (hs && mem_we) begin
        pops++;
        hs_log.push_back(1'b1);
        if (st_q.size() == 0) chk("unexpected_store", mem_addr, 32'hFFFF_FFFF);
        else begin
          e = st_q.pop_front();
          chk("store_addr", mem_addr, e.addr);
          chk("store_wdata", mem_wdata, e.data);
          chk("store_be", 32'(mem_be), 32'(e.be));
        end
        w = bus_rd({2'b00, mem_addr[31:2]});
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        bus_mem[{2'b00, mem_addr[31:2]}] = w;
      end
      if (hs && !mem_we) begin
        hs_log.push_back(1'b0);
        if (la_q.size() == 0) chk("unexpected_load_req", mem_addr, 32'hFFFF_FFFF);
        else chk("load_addr", mem_addr, la_q.pop_front());
        rv_pend = 1'b1;
        rv_cnt  = $urandom_range(rv_max, rv_min);
        rv_data = bus_rd({2'b00, mem_addr[31:2]});
      end
      @(posedge clk); #1;
      case (gnt_mode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = 1'($urandom_range(1, 0));
        2:       mem_gnt = 1'b0;
        default: mem_gnt = ~mem_gnt;
      endcase
      mem_rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
          rv_pend    = 1'b0;
        end else rv_cnt--;
      end
    end
  end

  task automatic prep(input bit rdo, input bit wro, input bit fen, input logic [2:0] fc,
                      input logic [31:0] a, input logic [31:0] d, output bit mis);
    logic [3:0]  be;
    logic [31:0] wd, w;
    mis = ((fc[1:0] == 2'b01) && a[0]) || (fc[1] && (a[1:0] != 2'b00));
    valid = 1'b1; memread = rdo; memwrite = wro; fence = fen;
    f3 = fc; addr = a; wr_data = d;
    if (wro && !mis) begin
      case (fc[1:0])
        2'b00:   be = 4'b0001 << a[1:0];
        2'b01:   be = 4'b0011 << a[1:0];
        default: be = 4'b1111;
      endcase
      wd = d << (8 * a[1:0]);
      st_q.push_back('{addr: {a[31:2], 2'b00}, data: wd, be: be});
      w = arch_rd({2'b00, a[31:2]});
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      arch_mem[{2'b00, a[31:2]}] = w;
    end
    if (rdo && !mis) begin
      rd_q.push_back(load_val(arch_rd({2'b00, a[31:2]}), a[1:0], fc));
      la_q.push_back({a[31:2], 2'b00});
    end
  endtask

  task automatic finish(input bit mis, output int sc);
    sc = 0;
    @(negedge clk);
    chk("ex_ld_addr", 32'(ex_ld), 32'(mis && memread));
    chk("ex_st_addr", 32'(ex_st), 32'(mis && memwrite));
    if (mis) chk("misaligned_stall", 32'(stall), 32'(0));
    while (stall === 1'b1) begin
      sc++;
      if (sc > 400) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stall still 1 after %0d cycles, required 0", sc);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    valid = 1'b0; memread = 1'b0; memwrite = 1'b0; fence = 1'b0;
  endtask

  task automatic issue(input bit rdo, input bit wro, input bit fen, input logic [2:0] fc,
                       input logic [31:0] a, input logic [31:0] d, output int sc);
    bit mis;
    prep(rdo, wro, fen, fc, a, d, mis);
    finish(mis, sc);
  endtask

  task automatic set_mode(input int m);
    gnt_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(sb_empty && !mem_req && !rv_pend) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("drain_done", 32'(sb_empty && !mem_req), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int sc, p0, k;
    bit mis;
    logic [2:0]  fc;
    logic [31:0] a;
    valid = 1'b0; memread = 1'b0; memwrite = 1'b0; fence = 1'b0;
    f3 = 3'b000; addr = '0; wr_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rd", rd, 32'h0);
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_be), 32'(0));
    chk("rst_sb_empty", 32'(sb_empty), 32'(1));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_ex", 32'({ex_ld, ex_st}), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-aliased load overtakes a buffered store.
    set_mode(0);
    hs_log.delete();
    issue(0, 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, sc);
    chk("sw_no_stall", 32'(sc), 32'(0));
    issue(1, 0, 0, 3'b010, 32'h200, 32'h0, sc);
    chk("lw_min_stall", 32'(sc), 32'(3));
    wait_drain();
    chk("t1_bus_ops", 32'(hs_log.size()), 32'(2));
    if (hs_log.size() == 2) begin
      chk("t1_load_first", 32'(hs_log[0]), 32'(0));
      chk("t1_store_second", 32'(hs_log[1]), 32'(1));
    end

    // Aliased byte load waits for the drain.
    hs_log.delete();
    issue(0, 1, 0, 3'b000, 32'h103, 32'h80, sc);
    issue(1, 0, 0, 3'b000, 32'h103, 32'h0, sc);
    chk("lb_alias_stall", 32'(sc > 3), 32'(1));
    issue(1, 0, 0, 3'b100, 32'h103, 32'h0, sc);
    wait_drain();
    chk("t2_bus_ops", 32'(hs_log.size()), 32'(3));
    if (hs_log.size() == 3) chk("t2_store_first", 32'(hs_log[0]), 32'(1));

    // Full buffer stalls the fifth store until the first pop.
    set_mode(2);
    for (int i = 0; i < 4; i++) begin
      issue(0, 1, 0, 3'b010, 32'h400 + 32'(4 * i), $urandom, sc);
      chk("fill_no_stall", 32'(sc), 32'(0));
    end
    p0 = pops;
    prep(0, 1, 0, 3'b010, 32'h410, 32'h12345678, mis);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_stall", 32'(stall), 32'(1));
      chk("full_not_empty", 32'(sb_empty), 32'(0));
    end
    gnt_mode = 0;
    finish(mis, sc);
    chk("full_push_after_one_pop", 32'(pops - p0), 32'(1));
    wait_drain();

    // Misaligned accesses.
    issue(1, 0, 0, 3'b001, 32'h101, 32'h0, sc);
    @(negedge clk);
    chk("mis_ld_no_req", 32'(mem_req), 32'(0));
    issue(0, 1, 0, 3'b010, 32'h102, 32'hCAFEF00D, sc);
    @(negedge clk);
    chk("mis_st_no_push", 32'(sb_empty), 32'(1));
    @(posedge clk); #1;

    // Fence with gnt every other cycle.
    set_mode(2);
    issue(0, 1, 0, 3'b010, 32'h300, 32'h11112222, sc);
    issue(0, 1, 0, 3'b010, 32'h304, 32'h33334444, sc);
    p0 = pops;
    gnt_mode = 3;
    issue(0, 0, 1, 3'b000, 32'h0, 32'h0, sc);
    chk("fence_stalled", 32'(sc >= 3), 32'(1));
    chk("fence_two_pops", 32'(pops - p0), 32'(2));
    chk("fence_sb_empty", 32'(sb_empty), 32'(1));
    set_mode(0);

    // Reset while the load waits for data.
    rv_min = 5; rv_max = 5;
    prep(1, 0, 0, 3'b010, 32'h40, 32'h0, mis);
    k = 0;
    while (la_q.size() != 0 && k < 20) begin @(negedge clk); k++; end
    chk("rst_ld_issued", 32'(la_q.size()), 32'(0));
    @(negedge clk);
    valid = 1'b0; memread = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'(0));
    chk("midrst_sb_empty", 32'(sb_empty), 32'(1));
    chk("midrst_rd", rd, 32'h0);
    rd_q.delete();
    rv_pend = 1'b0;
    rv_min = 0; rv_max = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 0, 0, 3'b010, 32'h40, 32'h0, sc);
    chk("post_rst_lw_stall", 32'(sc), 32'(3));

    // Randomized traffic over a small window so that aliasing is frequent.
    gnt_mode = 1; rv_min = 0; rv_max = 2;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(19, 0);
      a = 32'($urandom_range(31, 0));
      if (k < 9) begin
        case ($urandom_range(4, 0))
          0:       fc = 3'b000;
          1:       fc = 3'b001;
          2:       fc = 3'b010;
          3:       fc = 3'b100;
          default: fc = 3'b101;
        endcase
        issue(1, 0, 0, fc, a, 32'h0, sc);
      end else if (k < 18) begin
        fc = 3'($urandom_range(2, 0));
        issue(0, 1, 0, fc, a, $urandom, sc);
      end else begin
        issue(0, 0, 1, 3'b000, 32'h0, 32'h0, sc);
      end
    end
    wait_drain();
    chk("final_store_q", 32'(st_q.size()), 32'(0));
    chk("final_rd_q", 32'(rd_q.size()), 32'(0));
    chk("final_la_q", 32'(la_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
